// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage feeding the IF/ID register.
// A one-entry hold buffer absorbs a word that returns while decode is stalled.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  localparam logic [31:0] PC0 = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        redir_q, redir_d;
  logic [31:0] rtgt_q, rtgt_d;
  logic [31:0] hbuf_instr_q, hbuf_instr_d;
  logic [31:0] hbuf_pc4_q, hbuf_pc4_d;
  logic        started_q;

  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  assign tgt      = branch_target & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    redir_d      = redir_q;
    rtgt_d       = rtgt_q;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_pc4_d   = hbuf_pc4_q;
    imem_req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_taken) pc_d = tgt;
        // Stay one extra edge after reset release before the first request.
        if (started_q) state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d    = tgt;
            redir_d = 1'b0;
          end else begin
            redir_d = 1'b1;
            rtgt_d  = tgt;
          end
        end else if (imem_ready) begin
          if (redir_q) begin
            valid_d = 1'b0;
            pc_d    = rtgt_q;
            redir_d = 1'b0;
          end else if (!stall) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            hbuf_instr_d = imem_rdata;
            hbuf_pc4_d   = pc_plus4;
            state_d      = HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          valid_d      = 1'b0;
          pc_d         = tgt;
          hbuf_instr_d = 32'h0;
          hbuf_pc4_d   = 32'h0;
          state_d      = REQ;
        end else if (!stall) begin
          instr_d = hbuf_instr_q;
          pc4_d   = hbuf_pc4_q;
          valid_d = 1'b1;
          pc_d    = hbuf_pc4_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= PC0;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      redir_q      <= 1'b0;
      rtgt_q       <= 32'h0;
      hbuf_instr_q <= 32'h0;
      hbuf_pc4_q   <= 32'h0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      redir_q      <= redir_d;
      rtgt_q       <= rtgt_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_pc4_q   <= hbuf_pc4_d;
      started_q    <= 1'b1;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; expected IF/ID loads queue up when a
// fetch is driven and are popped once the register should have captured them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n, stall, br, ready;
  logic [31:0] tgt;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;
  logic        ifid_valid;

  logic        rst2_n, stall2, br2, ready2;
  logic [31:0] tgt2;
  logic        req2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;
  logic        valid2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = ready  ? mem(imem_addr) : 32'hDEAD_BEEF;
  assign rdata2     = ready2 ? mem(addr2)     : 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(br), .branch_target(tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(ready), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(stall2), .branch_taken(br2), .branch_target(tgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2), .imem_rdata(rdata2),
    .ifid_instr(instr2), .ifid_pc4(pc4_2), .ifid_valid(valid2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, {31'h0, ifid_valid}, 32'h1);
      chk({tag, ".instr"}, ifid_instr, e.instr);
      chk({tag, ".pc4"}, ifid_pc4, e.pc4);
    end
  endtask

  // Async reset checked before any edge, then release mid-cycle; optional IDLE branch.
  task automatic do_reset(input logic do_br, input logic [31:0] t, input logic [31:0] exp_pc);
    rst_n = 1'b0; ready = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    #1;
    chk("rst.req",   {31'h0, imem_req}, 32'h0);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.instr", ifid_instr, 32'h0);
    chk("rst.pc4",   ifid_pc4, 32'h0);
    chk("rst.valid", {31'h0, ifid_valid}, 32'h0);
    sb.delete();
    tick();
    chk("rst.ready_ignored", {31'h0, ifid_valid}, 32'h0);
    rst_n = 1'b1; br = do_br; tgt = t;
    tick();
    br = 1'b0;
    chk("idle.req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("first.req",  {31'h0, imem_req}, 32'h1);
    chk("first.addr", imem_addr, exp_pc);
  endtask

  task automatic fetch_step(input logic [31:0] a);
    ready = 1'b1; stall = 1'b0; br = 1'b0;
    chk("fetch.req",  {31'h0, imem_req}, 32'h1);
    chk("fetch.addr", imem_addr, a);
    sb.push_back('{instr: mem(a), pc4: a + 32'd4});
    tick();
    pop_chk("fetch.ifid");
  endtask

  task automatic wait_step(input logic [31:0] a);
    ready = 1'b0; stall = 1'b0; br = 1'b0;
    chk("wait.req",  {31'h0, imem_req}, 32'h1);
    chk("wait.addr", imem_addr, a);
    tick();
    chk("wait.valid", {31'h0, ifid_valid}, 32'h0);
  endtask

  initial begin
    stall2 = 1'b0; br2 = 1'b0; tgt2 = 32'h0; ready2 = 1'b1; rst2_n = 1'b0;

    // zero-wait streaming
    do_reset(1'b0, 32'h0, 32'h0);
    fetch_step(32'd0); fetch_step(32'd4); fetch_step(32'd8); fetch_step(32'd12);

    // three wait states at addr 8, then reset while waiting at 12
    do_reset(1'b0, 32'h0, 32'h0);
    fetch_step(32'd0); fetch_step(32'd4);
    wait_step(32'd8); wait_step(32'd8); wait_step(32'd8);
    fetch_step(32'd8);
    wait_step(32'd12);
    do_reset(1'b0, 32'h0, 32'h0);

    // stall on returning data at addr 4 -> HOLD
    fetch_step(32'd0);
    ready = 1'b1; stall = 1'b1;
    chk("hold.addr", imem_addr, 32'd4);
    sb.push_back('{instr: mem(32'd4), pc4: 32'd8});
    tick();
    chk("hold.req",   {31'h0, imem_req}, 32'h0);
    chk("hold.pc4",   ifid_pc4, 32'd4);
    chk("hold.instr", ifid_instr, mem(32'd0));
    chk("hold.valid", {31'h0, ifid_valid}, 32'h1);
    tick();
    chk("hold2.req", {31'h0, imem_req}, 32'h0);
    chk("hold2.pc4", ifid_pc4, 32'd4);
    stall = 1'b0;
    tick();
    pop_chk("hold.release");
    chk("hold.next_req",  {31'h0, imem_req}, 32'h1);
    chk("hold.next_addr", imem_addr, 32'd8);
    ready = 1'b0; stall = 1'b1;
    tick();
    chk("stallnoload.valid", {31'h0, ifid_valid}, 32'h1);
    chk("stallnoload.pc4",   ifid_pc4, 32'd8);
    chk("stallnoload.addr",  imem_addr, 32'd8);
    fetch_step(32'd8);

    // branches: while waiting (with overwrite), on ready, and in HOLD
    do_reset(1'b0, 32'h0, 32'h0);
    fetch_step(32'd0); fetch_step(32'd4); fetch_step(32'd8);
    ready = 1'b0; br = 1'b1; tgt = 32'h0000_0021;
    chk("brw.addr", imem_addr, 32'd12);
    tick();
    br = 1'b0;
    chk("brw.req",   {31'h0, imem_req}, 32'h1);
    chk("brw.addr2", imem_addr, 32'd12);
    chk("brw.valid", {31'h0, ifid_valid}, 32'h0);
    br = 1'b1; tgt = 32'h0000_0041;
    tick();
    br = 1'b0;
    chk("brw.overwrite_addr", imem_addr, 32'd12);
    ready = 1'b1;
    tick();
    chk("brw.discard_valid", {31'h0, ifid_valid}, 32'h0);
    chk("brw.redirect_addr", imem_addr, 32'h0000_0040);
    fetch_step(32'h40);
    ready = 1'b1; br = 1'b1; tgt = 32'h0000_0102;
    tick();
    br = 1'b0;
    chk("brr.valid", {31'h0, ifid_valid}, 32'h0);
    chk("brr.addr",  imem_addr, 32'h0000_0100);
    fetch_step(32'h100);
    ready = 1'b1; stall = 1'b1;
    tick();
    chk("brh.hold_req", {31'h0, imem_req}, 32'h0);
    br = 1'b1; tgt = 32'h0000_0200;
    tick();
    br = 1'b0;
    chk("brh.valid", {31'h0, ifid_valid}, 32'h0);
    chk("brh.req",   {31'h0, imem_req}, 32'h1);
    chk("brh.addr",  imem_addr, 32'h0000_0200);
    fetch_step(32'h200);

    // branch during IDLE
    do_reset(1'b1, 32'h0000_0303, 32'h0000_0300);
    fetch_step(32'h300);

    // wrap from 0xFFFF_FFFC
    rst2_n = 1'b1;
    tick();
    chk("wrap.idle_req", {31'h0, req2}, 32'h0);
    tick();
    chk("wrap.req",   {31'h0, req2}, 32'h1);
    chk("wrap.addr0", addr2, 32'hFFFF_FFFC);
    tick();
    chk("wrap.addr1", addr2, 32'h0000_0000);
    chk("wrap.pc4",   pc4_2, 32'h0000_0000);
    chk("wrap.instr", instr2, mem(32'hFFFF_FFFC));
    chk("wrap.valid", {31'h0, valid2}, 32'h1);
    tick();
    chk("wrap.addr2", addr2, 32'h0000_0004);
    chk("wrap.pc4b",  pc4_2, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
